// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the next-PC sequencer.
// State encoding, redirect priority codes and boot/exception addresses.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Higher code wins; the pending entry keeps its code for later compares.
  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_BR   = 3'd1,
    RD_JR   = 3'd2,
    RD_ERET = 3'd3,
    RD_EXC  = 3'd4
  } redir_e;

  typedef struct packed {
    redir_e      code;
    logic [31:0] addr;
  } redir_t;

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the next-PC sequencer and the rest of the pipeline.
// PC_ALIGN_CHECK_EN adds the adel (misaligned fetch target) flag.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        fetch_req;
  logic        redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
  logic        adel;
`endif

  // Sequencer side.
  modport master (
`ifdef PC_ALIGN_CHECK_EN
    output adel,
`endif
    input  pc_cur, hazard_stall, br_valid, br_target, jr_valid, jr_target,
    input  exc_req, eret_req, epc, imem_ready,
    output pc_next, pc_stall, fetch_req, redirect_pending
  );

  // Pipeline / memory side.
  modport slave (
`ifdef PC_ALIGN_CHECK_EN
    input  adel,
`endif
    output pc_cur, hazard_stall, br_valid, br_target, jr_valid, jr_target,
    output exc_req, eret_req, epc, imem_ready,
    input  pc_next, pc_stall, fetch_req, redirect_pending
  );
endinterface

// File: rtl/redirect_sel.sv
// Combinational priority mux over the live redirect requests.
// exc > eret > jr > br; returns RD_NONE when nothing is asserted.
module redirect_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  input  logic        i_jr_valid,
  input  logic [31:0] i_jr_target,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_target,
  output redir_t      o_sel
);

  // Fixed-priority pick of the winning redirect.
  always_comb begin
    o_sel = '{code: RD_NONE, addr: 32'd0};
    if (i_exc_req)       o_sel = '{code: RD_EXC,  addr: EXC_VECTOR};
    else if (i_eret_req) o_sel = '{code: RD_ERET, addr: i_epc};
    else if (i_jr_valid) o_sel = '{code: RD_JR,   addr: i_jr_target};
    else if (i_br_valid) o_sel = '{code: RD_BR,   addr: i_br_target};
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register input, freezes it while fetch or
// hazards block, and parks one redirect that arrives while frozen.
// Optional: PC_ALIGN_CHECK_EN turns misaligned targets into an exception.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  state_e      r_state;
  logic        r_pend_valid;
  logic [31:0] r_pend_addr;
  redir_e      r_pend_code;

  redir_t      w_live;
  logic        w_adv;
  logic        w_fetch;
  logic        w_take;
  logic [31:0] w_cand;
  logic [31:0] w_pc_next;
  logic        w_adel;

  redirect_sel #(.EXC_VECTOR(EXC_VECTOR)) u_sel (
    .i_exc_req   (bus.exc_req),
    .i_eret_req  (bus.eret_req),
    .i_epc       (bus.epc),
    .i_jr_valid  (bus.jr_valid),
    .i_jr_target (bus.jr_target),
    .i_br_valid  (bus.br_valid),
    .i_br_target (bus.br_target),
    .o_sel       (w_live)
  );

  // Per-state fetch request and the "PC advances this cycle" condition.
  always_comb begin
    w_adv   = 1'b0;
    w_fetch = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_fetch = 1'b1;
        w_adv   = bus.imem_ready && !bus.hazard_stall;
      end
      ST_WAIT: w_fetch = 1'b1;
      default: ;
    endcase
  end

  // Candidate target: live redirect first, then the parked one, then PC+4.
  // A live request replaces the parked one only at equal or higher rank;
  // exc carries the top code so it always wins.
  always_comb begin
    if (w_live.code != RD_NONE) w_cand = w_live.addr;
    else if (r_pend_valid)      w_cand = r_pend_addr;
    else                        w_cand = pc_inc(bus.pc_cur);
    w_take = !w_adv && (w_live.code != RD_NONE) &&
             (!r_pend_valid || (w_live.code >= r_pend_code));
  end

  // Final PC register input; BOOT (and reset) always shows the boot address.
  always_comb begin
    w_adel    = 1'b0;
    w_pc_next = (r_state == ST_BOOT) ? RESET_PC : w_cand;
`ifdef PC_ALIGN_CHECK_EN
    if (w_adv && (w_cand[1:0] != 2'b00)) begin
      w_pc_next = EXC_VECTOR;
      w_adel    = 1'b1;
    end
`endif
  end

  assign bus.pc_next          = w_pc_next;
  assign bus.pc_stall         = !w_adv;
  assign bus.fetch_req        = w_fetch;
  assign bus.redirect_pending = r_pend_valid;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.adel             = w_adel;
`else
  logic w_unused_adel;
  assign w_unused_adel = w_adel;
`endif

  // Fetch handshake FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT:  r_state <= ST_FETCH;
        ST_FETCH: if (!bus.imem_ready)      r_state <= ST_WAIT;
                  else if (bus.hazard_stall) r_state <= ST_HOLD;
        ST_WAIT:  if (bus.imem_ready)
                    r_state <= bus.hazard_stall ? ST_HOLD : ST_FETCH;
        ST_HOLD:  if (!bus.hazard_stall)     r_state <= ST_FETCH;
        default:  r_state <= ST_BOOT;
      endcase
    end
  end

  // Parked redirect: consumed on the advancing edge, captured while frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 32'd0;
      r_pend_code  <= RD_NONE;
    end else if (w_adv) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= RD_NONE;
    end else if (w_take) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= w_live.addr;
      r_pend_code  <= w_live.code;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; each scenario task checks inline.
// Build with PC_ALIGN_CHECK_EN defined to cover the adel path.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hazard_stall = 1'b0; bus.br_valid = 1'b0; bus.jr_valid = 1'b0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.imem_ready = 1'b1;
    bus.br_target = 32'h0; bus.jr_target = 32'h0; bus.epc = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.pc_cur = 32'h0;
    repeat (3) step();
    n_chk++; if (bus.pc_next !== 32'h3000) begin n_fail++; $display("FAIL rst_pc_next got %h want 00003000", bus.pc_next); end
    n_chk++; if (bus.pc_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b want 1", bus.pc_stall); end
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL rst_fetch got %b want 0", bus.fetch_req); end
    n_chk++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pend got %b want 0", bus.redirect_pending); end
    reset = 1'b1;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3000 || bus.pc_stall !== 1'b1 || bus.fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL boot_cycle got pc=%h stall=%b fetch=%b want 00003000/1/0", bus.pc_next, bus.pc_stall, bus.fetch_req); end
    step();
    bus.pc_cur = 32'h3000;
    #1;
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch got %b want 1", bus.fetch_req); end
    n_chk++; if (bus.pc_next !== 32'h3004 || bus.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL first_adv got pc=%h stall=%b want 00003004/0", bus.pc_next, bus.pc_stall); end
    step();
  endtask

  task automatic test_branch();
    bus.pc_cur = 32'h3010; bus.br_valid = 1'b1; bus.br_target = 32'h3100;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3100 || bus.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL br_taken got pc=%h stall=%b want 00003100/0", bus.pc_next, bus.pc_stall); end
    step();
    bus.br_valid = 1'b0;
    #1;
    n_chk++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL br_no_pend got %b want 0", bus.redirect_pending); end
  endtask

  task automatic test_stall_redirect();
    bus.pc_cur = 32'h3100; bus.hazard_stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h3200;
    #1;
    n_chk++; if (bus.pc_stall !== 1'b1 || bus.fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL hz_c1 got stall=%b fetch=%b want 1/1", bus.pc_stall, bus.fetch_req); end
    step();
    bus.br_valid = 1'b0; bus.jr_valid = 1'b1; bus.jr_target = 32'h3300;
    #1;
    n_chk++; if (bus.redirect_pending !== 1'b1 || bus.fetch_req !== 1'b0 || bus.pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL hz_c2 got pend=%b fetch=%b stall=%b want 1/0/1", bus.redirect_pending, bus.fetch_req, bus.pc_stall); end
    step();
    // lower-rank branch must not displace the parked jr
    bus.jr_valid = 1'b0; bus.br_valid = 1'b1; bus.br_target = 32'h3400;
    #1;
    n_chk++; if (bus.pc_stall !== 1'b1) begin n_fail++; $display("FAIL hz_c3 stall got %b want 1", bus.pc_stall); end
    step();
    bus.br_valid = 1'b0; bus.hazard_stall = 1'b0;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3300 || bus.pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL hz_leave got pc=%h stall=%b want 00003300/1", bus.pc_next, bus.pc_stall); end
    step();
    #0;
    n_chk++; if (bus.pc_next !== 32'h3300 || bus.pc_stall !== 1'b0 || bus.redirect_pending !== 1'b1) begin
      n_fail++; $display("FAIL hz_apply got pc=%h stall=%b pend=%b want 00003300/0/1", bus.pc_next, bus.pc_stall, bus.redirect_pending); end
    step();
    bus.pc_cur = 32'h3300;
    #1;
    n_chk++; if (bus.redirect_pending !== 1'b0 || bus.pc_next !== 32'h3304) begin
      n_fail++; $display("FAIL hz_clear got pend=%b pc=%h want 0/00003304", bus.redirect_pending, bus.pc_next); end
  endtask

  task automatic test_wait_exc();
    bus.imem_ready = 1'b0;
    #1;
    n_chk++; if (bus.pc_stall !== 1'b1 || bus.fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL wait_enter got stall=%b fetch=%b want 1/1", bus.pc_stall, bus.fetch_req); end
    step();
    for (int i = 0; i < 3; i++) begin
      bus.exc_req = (i == 1);
      #1;
      n_chk++; if (bus.pc_stall !== 1'b1 || bus.fetch_req !== 1'b1) begin
        n_fail++; $display("FAIL wait_cyc%0d got stall=%b fetch=%b want 1/1", i, bus.pc_stall, bus.fetch_req); end
      step();
    end
    bus.exc_req = 1'b0; bus.imem_ready = 1'b1;
    #1;
    n_chk++; if (bus.pc_stall !== 1'b1 || bus.redirect_pending !== 1'b1) begin
      n_fail++; $display("FAIL wait_done got stall=%b pend=%b want 1/1", bus.pc_stall, bus.redirect_pending); end
    step();
    n_chk++; if (bus.pc_next !== 32'h4180 || bus.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL exc_apply got pc=%h stall=%b want 00004180/0", bus.pc_next, bus.pc_stall); end
    step();
    n_chk++; if (bus.redirect_pending !== 1'b0) begin n_fail++; $display("FAIL exc_clear got %b want 0", bus.redirect_pending); end
  endtask

  task automatic test_priority();
    bus.pc_cur = 32'h4180; bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3020;
    bus.br_valid = 1'b1; bus.br_target = 32'h3500;
    #1;
    n_chk++; if (bus.pc_next !== 32'h4180 || bus.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL prio_exc got pc=%h stall=%b want 00004180/0", bus.pc_next, bus.pc_stall); end
    step();
    bus.exc_req = 1'b0; bus.br_valid = 1'b0;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3020) begin n_fail++; $display("FAIL prio_eret got %h want 00003020", bus.pc_next); end
    step();
    bus.eret_req = 1'b0; bus.jr_valid = 1'b1; bus.jr_target = 32'h3600;
    bus.br_valid = 1'b1; bus.br_target = 32'h3700;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3600) begin n_fail++; $display("FAIL prio_jr got %h want 00003600", bus.pc_next); end
    step();
    bus.jr_valid = 1'b0; bus.br_valid = 1'b0; bus.pc_cur = 32'hFFFF_FFFC;
    #1;
    n_chk++; if (bus.pc_next !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got %h want 00000000", bus.pc_next); end
    step();
  endtask

  task automatic test_align();
    bus.pc_cur = 32'h3100; bus.jr_valid = 1'b1; bus.jr_target = 32'h3102;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    n_chk++; if (bus.pc_next !== 32'h4180 || bus.adel !== 1'b1) begin
      n_fail++; $display("FAIL adel_hit got pc=%h adel=%b want 00004180/1", bus.pc_next, bus.adel); end
`else
    n_chk++; if (bus.pc_next !== 32'h3102) begin n_fail++; $display("FAIL no_align got %h want 00003102", bus.pc_next); end
`endif
    step();
    bus.jr_valid = 1'b0; bus.pc_cur = 32'h3000;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    n_chk++; if (bus.adel !== 1'b0) begin n_fail++; $display("FAIL adel_drop got %b want 0", bus.adel); end
`endif
    n_chk++; if (bus.pc_next !== 32'h3004) begin n_fail++; $display("FAIL align_after got %h want 00003004", bus.pc_next); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.hazard_stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h3800;
    #1;
    step();
    bus.br_valid = 1'b0;
    #1;
    n_chk++; if (bus.redirect_pending !== 1'b1) begin n_fail++; $display("FAIL mid_pend got %b want 1", bus.redirect_pending); end
    reset = 1'b0;
    #1;
    n_chk++; if (bus.redirect_pending !== 1'b0 || bus.pc_next !== 32'h3000 || bus.pc_stall !== 1'b1 || bus.fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got pend=%b pc=%h stall=%b fetch=%b want 0/00003000/1/0",
                         bus.redirect_pending, bus.pc_next, bus.pc_stall, bus.fetch_req); end
    step();
    reset = 1'b1; bus.hazard_stall = 1'b0;
    #1;
    n_chk++; if (bus.fetch_req !== 1'b0 || bus.pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL mid_boot got fetch=%b stall=%b want 0/1", bus.fetch_req, bus.pc_stall); end
    step();
    bus.pc_cur = 32'h3000;
    #1;
    n_chk++; if (bus.pc_next !== 32'h3004 || bus.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_restart got pc=%h stall=%b want 00003004/0", bus.pc_next, bus.pc_stall); end
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_branch();
    test_stall_redirect();
    test_wait_exc();
    test_priority();
    test_align();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
